// File: rtl/leaf_arb_pkg.sv
// ---------------------------------------------------------------------------
// leaf_arb_pkg : shared state encoding and default sizes for leaf_out_arbiter
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package leaf_arb_pkg;

   localparam int c_num_ports     = 4;
   localparam int c_payload_bits  = 32;
   localparam int c_num_port_bits = 4;
   localparam int c_burst_len     = 8;
   localparam int c_max_credits   = 64;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_priority_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker : combinational round-robin pick starting after last_grant
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_priority_picker #(
   parameter int N        = 4,
   parameter int IDX_BITS = 4
) (
   input  logic [N-1:0]        req,
   input  logic [IDX_BITS-1:0] last_grant,
   output logic [N-1:0]        grant,
   output logic [IDX_BITS-1:0] grant_idx,
   output logic                any_grant
);

   int w_dist;
   int w_best;

   // distance 0 is the port right after last_grant; the smallest distance wins
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      w_dist    = 0;
      w_best    = N;
      for (int i = 0; i < N; i++) begin
         w_dist = (i + N - (int'(last_grant) % N) - 1) % N;
         if (req[i] && (w_dist < w_best)) begin
            w_best    = w_dist;
            grant     = '0;
            grant[i]  = 1'b1;
            grant_idx = IDX_BITS'(i);
            any_grant = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/leaf_out_arbiter.sv
// ---------------------------------------------------------------------------
// leaf_out_arbiter : credit-gated round-robin burst arbiter onto one leaf stream
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module leaf_out_arbiter
   import leaf_arb_pkg::*;
#(
   parameter int NUM_PORTS     = c_num_ports,
   parameter int PAYLOAD_BITS  = c_payload_bits,
   parameter int NUM_PORT_BITS = c_num_port_bits,
   parameter int BURST_LEN     = c_burst_len,
   parameter int MAX_CREDITS   = c_max_credits
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_PORTS*PAYLOAD_BITS-1:0] din_user2arb,
   input  logic [NUM_PORTS-1:0]              vld_user2arb,
   output logic [NUM_PORTS-1:0]              ack_arb2user,
   output logic [PAYLOAD_BITS-1:0]           dout_arb2interface,
   output logic [NUM_PORT_BITS-1:0]          port_arb2interface,
   output logic                              vld_arb2interface,
   input  logic                              ack_interface2arb,
   input  logic [NUM_PORTS-1:0]              credit_return,
   output logic                              credit_ovf,
   output logic                              busy
);

   localparam int CREDIT_BITS = $clog2(MAX_CREDITS + 1);
   localparam int CNT_BITS    = $clog2(BURST_LEN + 1);

   localparam logic [CREDIT_BITS-1:0] c_credit_max = CREDIT_BITS'(MAX_CREDITS);
   localparam logic [CREDIT_BITS-1:0] c_credit_one = CREDIT_BITS'(1);
   localparam logic [CNT_BITS-1:0]    c_cnt_last   = CNT_BITS'(BURST_LEN - 1);
   localparam logic [CNT_BITS-1:0]    c_cnt_one    = CNT_BITS'(1);

   arb_state_t                r_state;
   arb_state_t                w_state_nxt;
   logic [NUM_PORT_BITS-1:0]  r_grant;
   logic [NUM_PORT_BITS-1:0]  r_last_grant;
   logic [CNT_BITS-1:0]       r_burst_cnt;
   logic [CREDIT_BITS-1:0]    r_credit [NUM_PORTS];
   logic                      r_out_vld;
   logic [PAYLOAD_BITS-1:0]   r_out_data;
   logic [NUM_PORT_BITS-1:0]  r_out_tag;
   logic                      r_ovf;

   logic [NUM_PORTS-1:0]      w_sel;
   logic [NUM_PORTS-1:0]      w_eligible;
   logic [NUM_PORTS-1:0]      w_ovf_hit;
   logic [NUM_PORTS-1:0]      w_pick_onehot;
   logic [NUM_PORT_BITS-1:0]  w_pick_idx;
   logic                      w_pick_any;
   logic                      w_g_elig;
   logic                      w_out_free;
   logic                      w_capture;
   logic                      w_start;
   logic                      w_exit;
   logic [PAYLOAD_BITS-1:0]   w_g_data;

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign w_sel[gi]      = (r_grant == NUM_PORT_BITS'(gi));
      assign w_eligible[gi] = vld_user2arb[gi] & (r_credit[gi] != '0);
      assign w_ovf_hit[gi]  = credit_return[gi] & ~ack_arb2user[gi] & (r_credit[gi] == c_credit_max);
   end

   rr_priority_picker #(
      .N        (NUM_PORTS),
      .IDX_BITS (NUM_PORT_BITS)
   ) u_picker (
      .req        (w_eligible),
      .last_grant (r_last_grant),
      .grant      (w_pick_onehot),
      .grant_idx  (w_pick_idx),
      .any_grant  (w_pick_any)
   );

   assign w_g_elig   = |(w_sel & w_eligible);
   assign w_out_free = ~r_out_vld | ack_interface2arb;

   always_comb begin
      w_g_data = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (w_sel[i]) w_g_data |= din_user2arb[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_start     = 1'b0;
      w_exit      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pick_any) begin
               w_state_nxt = SEND;
               w_start     = 1'b1;
            end
         end
         SEND: begin
            if (w_g_elig && w_out_free) begin
               w_capture = 1'b1;
               if (r_burst_cnt == c_cnt_last) begin
                  w_state_nxt = IDLE;
                  w_exit      = 1'b1;
               end
            end else if (!w_g_elig) begin
               // stalled purely by downstream backpressure keeps the grant
               w_state_nxt = IDLE;
               w_exit      = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign ack_arb2user = w_capture ? w_sel : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_grant      <= '0;
         r_last_grant <= NUM_PORT_BITS'(NUM_PORTS - 1);
         r_burst_cnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start) begin
            r_grant     <= w_pick_idx;
            r_burst_cnt <= '0;
         end else if (w_capture) begin
            r_burst_cnt <= r_burst_cnt + c_cnt_one;
         end
         if (w_exit) r_last_grant <= r_grant;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out_vld  <= 1'b0;
         r_out_data <= '0;
         r_out_tag  <= '0;
      end else if (w_capture) begin
         r_out_vld  <= 1'b1;
         r_out_data <= w_g_data;
         r_out_tag  <= r_grant;
      end else if (ack_interface2arb) begin
         r_out_vld  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_PORTS; i++) r_credit[i] <= c_credit_max;
         r_ovf <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (ack_arb2user[i] && !credit_return[i]) begin
               r_credit[i] <= r_credit[i] - c_credit_one;
            end else if (!ack_arb2user[i] && credit_return[i] && (r_credit[i] != c_credit_max)) begin
               r_credit[i] <= r_credit[i] + c_credit_one;
            end
         end
         if (|w_ovf_hit) r_ovf <= 1'b1;
      end
   end

   assign dout_arb2interface = r_out_data;
   assign port_arb2interface = r_out_tag;
   assign vld_arb2interface  = r_out_vld;
   assign credit_ovf         = r_ovf;
   assign busy               = (r_state != IDLE) | r_out_vld;

endmodule

`default_nettype wire

// File: tb/tb_leaf_out_arbiter.sv
// ---------------------------------------------------------------------------
// tb_leaf_out_arbiter : scoreboard bench with directed scenarios and random traffic
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_leaf_out_arbiter;

   localparam int NP  = 4;
   localparam int PB  = 32;
   localparam int NPB = 4;
   localparam int BL  = 8;
   localparam int MC  = 64;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [NP*PB-1:0] din = '0;
   logic [NP-1:0]    vld = '0;
   logic [NP-1:0]    ack_u;
   logic [PB-1:0]    dout;
   logic [NPB-1:0]   tag;
   logic             vld_o;
   logic             ack_i = 1'b0;
   logic [NP-1:0]    cret = '0;
   logic             ovf;
   logic             busy;

   always #5 clk = ~clk;

   leaf_out_arbiter #(
      .NUM_PORTS     (NP),
      .PAYLOAD_BITS  (PB),
      .NUM_PORT_BITS (NPB),
      .BURST_LEN     (BL),
      .MAX_CREDITS   (MC)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .din_user2arb       (din),
      .vld_user2arb       (vld),
      .ack_arb2user       (ack_u),
      .dout_arb2interface (dout),
      .port_arb2interface (tag),
      .vld_arb2interface  (vld_o),
      .ack_interface2arb  (ack_i),
      .credit_return      (cret),
      .credit_ovf         (ovf),
      .busy               (busy)
   );

   typedef struct packed {
      logic [NPB-1:0] tag;
      logic [PB-1:0]  data;
   } word_t;

   int            total = 0;
   int            bad   = 0;
   int            cyc   = 0;
   int            seq   = 0;
   word_t         scb [$];
   logic [PB-1:0] src_q [NP][$];
   int            out_tags [$];
   int            out_cycs [$];
   int            model_credit [NP];
   logic          model_ovf = 1'b0;
   logic [NP-1:0] gate = '1;
   logic [NP-1:0] auto_ret = '0;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int count_tag(input int t);
      int n = 0;
      foreach (out_tags[k]) if (out_tags[k] == t) n++;
      return n;
   endfunction

   task automatic push_words(input int port, input int n);
      for (int k = 0; k < n; k++) begin
         src_q[port].push_back({8'(port), 24'(seq)});
         seq++;
      end
   endtask

   // Monitor: every downstream handshake pops the scoreboard; unacked words must hold
   word_t          mon_exp;
   logic           prev_hold = 1'b0;
   logic [PB-1:0]  prev_dout = '0;
   logic [NPB-1:0] prev_tag  = '0;

   always @(negedge clk) begin
      if (!reset) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_vld", vld_o, 1);
            chk("hold_data", dout, prev_dout);
            chk("hold_tag", tag, prev_tag);
         end
         if (vld_o && ack_i) begin
            chk("out_expected_avail", scb.size() > 0, 1);
            if (scb.size() > 0) begin
               mon_exp = scb.pop_front();
               chk("out_tag", tag, mon_exp.tag);
               chk("out_data", dout, mon_exp.data);
            end
            out_tags.push_back(int'(tag));
            out_cycs.push_back(cyc);
         end
         prev_hold = vld_o && !ack_i;
         prev_dout = dout;
         prev_tag  = tag;
      end
   end

   // One clock of stimulus: present sources, judge user handshakes, commit the model
   task automatic cycle();
      logic [NP-1:0] cap;
      word_t         w;
      for (int i = 0; i < NP; i++) begin
         vld[i]            = gate[i] && (src_q[i].size() > 0);
         din[i*PB +: PB]   = (src_q[i].size() > 0) ? src_q[i][0] : '0;
      end
      @(negedge clk);
      cap  = ack_u & vld;
      cret = cret | (cap & auto_ret);
      chk("ack_without_vld", ack_u & ~vld, 0);
      chk("ack_onehot", $countones(ack_u) <= 1, 1);
      chk("credit_ovf", ovf, model_ovf);
      if (|ack_u) chk("ack_backpressure", !vld_o || ack_i, 1);
      for (int i = 0; i < NP; i++) begin
         if (cap[i]) begin
            chk("ack_credit", model_credit[i] > 0, 1);
            w.tag  = NPB'(i);
            w.data = src_q[i][0];
            scb.push_back(w);
         end
      end
      @(posedge clk);
      for (int i = 0; i < NP; i++) begin
         if (cap[i] && !cret[i]) begin
            model_credit[i]--;
         end else if (!cap[i] && cret[i]) begin
            if (model_credit[i] == MC) model_ovf = 1'b1;
            else model_credit[i]++;
         end
         if (cap[i]) void'(src_q[i].pop_front());
      end
      cyc++;
      #1;
      cret = '0;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic run_until(input string name, input int n, input int budget);
      int k = 0;
      while (out_tags.size() < n && k < budget) begin
         cycle();
         k++;
      end
      chk(name, out_tags.size(), n);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk("rst_vld", vld_o, 0);
      chk("rst_dout", dout, 0);
      chk("rst_tag", tag, 0);
      chk("rst_ack", ack_u, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_busy", busy, 0);
      scb.delete();
      out_tags.delete();
      out_cycs.delete();
      for (int i = 0; i < NP; i++) begin
         src_q[i].delete();
         model_credit[i] = MC;
      end
      model_ovf = 1'b0;
      vld = '0; din = '0; cret = '0; ack_i = 1'b0;
      gate = '1; auto_ret = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      #200000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int sz;
      int left;
      int k;
      #2;
      do_reset();

      // Two sources, three words each: port 0 first, then port 2
      push_words(0, 3);
      push_words(2, 3);
      ack_i = 1'b1;
      c0 = cyc;
      run_until("two_src_count", 6, 40);
      if (out_tags.size() == 6) begin
         for (int j = 0; j < 6; j++) chk("two_src_order", out_tags[j], (j < 3) ? 0 : 2);
         for (int j = 0; j < 3; j++) chk("two_src_latency", out_cycs[j], c0 + 2 + j);
      end

      // Burst cap: port 1 long, port 3 waiting
      do_reset();
      push_words(1, 20);
      push_words(3, 4);
      ack_i = 1'b1;
      run_until("burst_count", 24, 80);
      if (out_tags.size() == 24) begin
         for (int j = 0; j < 24; j++)
            chk("burst_order", out_tags[j], (j < BL) ? 1 : ((j < BL + 4) ? 3 : 1));
      end

      // Credit drain on port 0, other port still served, single credit refill
      do_reset();
      push_words(0, 70);
      push_words(1, 3);
      ack_i = 1'b1;
      run(160);
      chk("drain_port0", count_tag(0), MC);
      chk("drain_port1", count_tag(1), 3);
      cret = 4'b0001;
      cycle();
      run(20);
      chk("refill_port0", count_tag(0), MC + 1);

      // Downstream stall mid-burst
      do_reset();
      push_words(2, 10);
      ack_i = 1'b1;
      run(4);
      chk("stall_pending", vld_o, 1);
      ack_i = 1'b0;
      sz = out_tags.size();
      run(5);
      chk("stall_no_output", out_tags.size(), sz);
      ack_i = 1'b1;
      run_until("stall_count", 10, 40);

      // Overflow on a full port, capture with same-cycle return on another
      do_reset();
      cret = 4'b0100;
      cycle();
      chk("ovf_set", ovf, 1);
      push_words(1, 10);
      ack_i    = 1'b1;
      auto_ret = 4'b0010;
      run_until("same_cycle_count", 10, 60);
      auto_ret = '0;
      push_words(1, 100);
      run(200);
      chk("same_cycle_credit", count_tag(1), 10 + MC);
      chk("ovf_sticky", ovf, 1);

      // Asynchronous reset with a word pending
      do_reset();
      push_words(0, 3);
      push_words(1, 5);
      ack_i = 1'b1;
      run_until("prereset_count", 4, 40);
      ack_i = 1'b0;
      run(3);
      chk("prereset_pending", vld_o, 1);
      chk("prereset_busy", busy, 1);
      #2;
      do_reset();
      push_words(0, 1);
      push_words(2, 1);
      ack_i = 1'b1;
      run_until("postreset_count", 2, 20);
      if (out_tags.size() == 2) begin
         chk("postreset_first", out_tags[0], 0);
         chk("postreset_second", out_tags[1], 2);
      end

      // Random traffic against the scoreboard and credit model
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < NP; i++) begin
            if ($urandom_range(3) == 0) push_words(i, 1);
            gate[i] = ($urandom_range(3) != 0);
            cret[i] = ($urandom_range(5) == 0);
         end
         ack_i = ($urandom_range(3) != 0);
         cycle();
      end
      gate  = '1;
      ack_i = 1'b1;
      k     = 0;
      left  = 1;
      while (left != 0 && k < 3000) begin
         cret = '1;
         cycle();
         k++;
         left = scb.size() + int'(vld_o);
         for (int i = 0; i < NP; i++) left += src_q[i].size();
      end
      chk("random_drained", left, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/leaf_out_arbiter.md
LEAF_OUT_ARBITER -- requirements
Module: leaf_out_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4: number of user output streams sharing one leaf_interface input.
REQ-002 The block SHALL have parameter PAYLOAD_BITS, default 32: word width per stream.
REQ-003 The block SHALL have parameter NUM_PORT_BITS, default 4: width of the port tag.
REQ-004 The block SHALL have parameter BURST_LEN, default 8: maximum words per grant.
REQ-005 The block SHALL have parameter MAX_CREDITS, default 64: per-port credit ceiling and reset value; CREDIT_BITS = clog2(MAX_CREDITS+1).
REQ-006 The block SHALL have port clk  in  1: the single clock; all logic is on the rising edge.
REQ-007 The block SHALL have port reset  in  1: asynchronous, active-low reset.
REQ-008 The block SHALL have port din_user2arb  in  NUM_PORTS*PAYLOAD_BITS: packed user words; port i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
REQ-009 The block SHALL have port vld_user2arb  in  NUM_PORTS: per-port ap_vld.
REQ-010 The block SHALL have port ack_arb2user  out  NUM_PORTS: per-port ap_ack; it is one-hot or zero.
REQ-011 The block SHALL have port dout_arb2interface  out  PAYLOAD_BITS: granted word.
REQ-012 The block SHALL have port port_arb2interface  out  NUM_PORT_BITS: index of the source port of dout.
REQ-013 The block SHALL have port vld_arb2interface  out  1: output word valid.
REQ-014 The block SHALL have port ack_interface2arb  in  1: downstream accept.
REQ-015 The block SHALL have port credit_return  in  NUM_PORTS: each 1-cycle pulse returns one credit to port i.
REQ-016 The block SHALL have port credit_ovf  out  1: sticky flag for a return at MAX_CREDITS.
REQ-017 The block SHALL have port busy  out  1: high when the FSM is not in IDLE or the output register is valid.

Function
REQ-018 The block SHALL complete a transfer on any stream in a cycle where vld and ack are both high.
REQ-019 The FSM SHALL have exactly two states, IDLE and SEND.
REQ-020 In IDLE, the block SHALL select the eligible port (vld=1 and credit>0) that comes first in round-robin order from last_grant+1 mod NUM_PORTS, and SHALL move to SEND next cycle; it SHALL drive no ack in IDLE.
REQ-021 In SEND, ack_arb2user[g] SHALL equal vld_user2arb[g] & (credit[g]>0) & (!vld_arb2interface | ack_interface2arb).
REQ-022 On a capture, the block SHALL register the word and port tag, SHALL assert vld_arb2interface on the next cycle (latency 1), and SHALL decrement credit[g].
REQ-023 The block SHALL hold vld_arb2interface, the word and the tag stable until ack_interface2arb; back-to-back captures SHALL sustain 1 word/cycle when downstream acks every cycle.
REQ-024 SEND SHALL return to IDLE after the BURST_LEN-th capture, or in any cycle where vld_user2arb[g]=0 or credit[g]=0 with no capture; last_grant SHALL be updated to g on exit.
REQ-025 Every IDLE-to-SEND arbitration SHALL cost exactly one bubble cycle.
REQ-026 With no eligible port, the block SHALL remain in IDLE.
REQ-027 A simultaneous capture and credit_return on the same port SHALL leave the credit unchanged.
REQ-028 A credit_return while credit = MAX_CREDITS (with no same-cycle capture) SHALL be ignored and SHALL set credit_ovf, which is cleared only by reset.
REQ-029 The output register SHALL be independent of the FSM: a pending word SHALL still be delivered after SEND exits.

Reset
REQ-030 While reset=0, the block SHALL force: state=IDLE, last_grant=NUM_PORTS-1 (so port 0 is first), every credit=MAX_CREDITS, burst count=0, vld_arb2interface=0, dout=0, tag=0, ack_arb2user=0, credit_ovf=0, busy=0.
REQ-031 Reset mid-burst SHALL discard any pending output word; there SHALL be no partial-word replay.
REQ-032 The block SHALL resume normal operation on the first rising edge after reset deasserts.

Structure
REQ-033 Package leaf_arb_pkg SHALL hold the state enum (IDLE, SEND) and the default parameter constants.
REQ-034 One sub-module, rr_priority_picker, SHALL be used: combinational, taking a request vector and last_grant and returning a one-hot grant and its index.
REQ-035 All credit counters SHALL saturate, never wrap.

Verification
REQ-036 Ports 0 and 2 each with 3 words, downstream always acks -> port 0 words at cycles 2-4 with tag 0, one bubble, then port 2 words with tag 2.
REQ-037 Port 1 holding 20 words, BURST_LEN=8, port 3 requesting -> 8 words from port 1, then port 3, then port 1 again.
REQ-038 Port 0 with credit drained to 0 while still valid -> SEND exits, port 0 is skipped; one credit_return -> exactly one more port 0 word.
REQ-039 ack_interface2arb held low for 5 cycles mid-burst -> dout and tag held stable, ack_arb2user=0, credits unchanged.
REQ-040 credit_return on port 2 at MAX_CREDITS -> credit stays 64 and credit_ovf=1; a same-cycle capture and return on port 1 -> credit unchanged.
REQ-041 Reset asserted mid-burst with an output word pending -> all outputs 0 immediately (asynchronously), and port 0 is granted first after release.
